jpeg_stream_sequencer: RTL and testbench
========================================

Name: jpeg_stream_sequencer

Overview:
- Frames one JPEG image on the 32-bit word stream.
- Per frame it emits, in order:
  - a host-loaded header (SOI through SOS) from local RAM;
  - the entropy-coded words from the byte packer, passed through;
  - one EOI word.
- Sits between the byte packer output and the image buffer writer. Tracks the frame byte count and signals done.
- All words are big-endian (first byte in [31:24]) and always fully valid.

Parameters:
- HDR_DEPTH, 256, header RAM depth in 32-bit words.
- EOI_WORD, 32'hFFFF_FFD9, trailer word: two fill bytes, then the EOI marker.
- SIZE_W, 20, width of the byte counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; begins a frame when idle
- abort  in  1  level; kills the current frame
- hdr_len  in  8  header length in words; sampled at start; 0 means no header
- hdr_wr_en  in  1  header RAM write strobe
- hdr_wr_addr  in  8  header RAM word address
- hdr_wr_data  in  32  header RAM write data
- in_data  in  32  packed entropy word from the byte packer
- in_tlast  in  1  last entropy word of the frame
- in_valid  in  1  input word valid
- in_hold  out  1  backpressure to the byte packer
- out_data  out  32  framed output word
- out_tlast  out  1  marks the EOI word
- out_valid  out  1  output word valid
- out_hold  in  1  downstream backpressure
- size  out  SIZE_W  bytes emitted in the current/last frame
- busy  out  1  high from accepted start until done or abort
- done  out  1  single-cycle pulse after the EOI word is accepted

Behaviour:
- Handshake:
  - A word transfers on a cycle with out_valid & ~out_hold.
  - While out_valid & out_hold, out_data and out_tlast are held stable.
  - All outputs are registered.
- Reset values:
  - out_valid=0, out_tlast=0, out_data=0, in_hold=1.
  - busy=0, done=0, size=0.
  - FSM in IDLE.
  - Header RAM contents are not reset.
- FSM: IDLE -> HDR -> BODY -> EOI -> DONE -> IDLE.
- IDLE:
  - in_hold=1.
  - start moves to HDR, or to BODY if hdr_len=0.
  - start also latches hdr_len, clears size, and sets busy the next cycle.
- HDR:
  - Header RAM read is synchronous (1-cycle).
  - First header word is on out_valid 2 cycles after start.
  - Words 0..hdr_len-1 are emitted back-to-back when not held.
  - Move to BODY after word hdr_len-1 transfers.
  - in_hold=1 throughout.
- BODY:
  - Registered pass-through, 1-cycle latency.
  - in_hold = ~(state==BODY) | (out_valid & out_hold).
  - Full throughput of 1 word/clk when out_hold=0.
  - When the word with in_tlast is accepted, move to EOI; in_hold=1 from the next cycle.
  - in_tlast is not forwarded to out_tlast.
- EOI:
  - Emit EOI_WORD with out_tlast=1.
  - On transfer go to DONE.
- DONE:
  - done=1 for one cycle, busy=0, return to IDLE.
- Size:
  - +4 on every transfer.
  - Saturates at 2^SIZE_W-4, never wraps.
  - Holds its value after done until the next start.
- Header writes:
  - Accepted only while IDLE; ignored while busy.
  - A write and start in the same cycle: the write happens, and the read sees the new data.
- start while busy is ignored.
- abort, in any non-IDLE state:
  - Next edge: IDLE, out_valid=0, busy=0, in_hold=1, no done pulse.
  - size keeps its partial count.
  - Any output word pending in hold is discarded.
  - abort has priority over start in the same cycle.
- Body with in_valid low: no bubble words are emitted; the FSM waits.
- hdr_len > HDR_DEPTH is impossible by width when HDR_DEPTH=256. For smaller depths the address wraps modulo HDR_DEPTH.

Decomposition:
- Shared package jpeg_pkg holds:
  - the seq_state_t enum (IDLE, HDR, BODY, EOI, DONE);
  - constants JPEG_EOI_WORD and JPEG_SIZE_W.
- One sub-module, hdr_ram: single-port write, synchronous read, HDR_DEPTH x 32, maps to EBR.
- The FSM, output register and counter stay in the top module.

Test Plan:
- Header and body:
  - Stimulus: load words 0..3 = 0xFFD8FFE0, 0x00104A46, 0x49460001, 0xFFDA000C; hdr_len=4; start; feed 3 body words 0xA1A2A3A4..0xC1C2C3C4, the last with in_tlast.
  - Expect: out stream = 4 header words, 3 body words, then 0xFFFFFFD9 with out_tlast=1; done one cycle after the EOI transfer; size=32; busy low after done.
- Zero-length header:
  - Stimulus: hdr_len=0; start; one body word with tlast.
  - Expect: first output is the body word (≤2 cycles after in_valid); then EOI; size=8.
- Backpressure:
  - Stimulus: out_hold randomly 50% asserted across header and body.
  - Expect: out_data stable while held; no word lost or duplicated; in_hold high whenever out_valid & out_hold; final size equals 4 × words transferred.
- Abort:
  - Stimulus: abort while in BODY after 2 body words accepted.
  - Expect: next cycle out_valid=0, busy=0, in_hold=1; no done pulse; size=4×(hdr_len+2) if no word was pending under hold.
  - Then a new start: a clean frame with size restarting from 0.
- Illegal start and header write while busy:
  - Stimulus: during a frame, assert start and hdr_wr_en to addr 0 with 0xDEADBEEF.
  - Expect: the frame is unaffected and the second start is ignored; the next frame's word 0 is still the original value.
- Size saturation:
  - Stimulus: SIZE_W=8 build; 70-word body.
  - Expect: size saturates at 252 and does not wrap.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG stream sequencer.
//   seq_state_t    : sequencer FSM states
//   JPEG_EOI_WORD  : trailer word, two 0xFF fill bytes then the EOI marker
//   JPEG_SIZE_W    : default width of the frame byte counter
package jpeg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StBody,
      StEoi,
      StDone
   } seq_state_t;

   localparam logic [31:0] JPEG_EOI_WORD = 32'hFFFF_FFD9;
   localparam int unsigned JPEG_SIZE_W   = 20;

endpackage

// File: rtl/hdr_ram.sv
// Header RAM: Depth x 32, one write port, one synchronous read port.
//   clk      : clock
//   we_i     : write strobe
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address, data appears on rdata_o after the next edge
//   rdata_o  : registered read data
// Contents are never reset so the array maps onto block RAM.
module hdr_ram #(
   parameter int unsigned Depth = 256,
   parameter int unsigned AddrW = 8
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [31:0]      wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [Depth];
   logic [31:0] rdata_q;

   // Write-first: a read of the address being written returns the new data,
   // so a header write in the same cycle as start is seen by the first read.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (we_i && (waddr_i == raddr_i)) begin
         rdata_q <= wdata_i;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_stream_sequencer.sv
// Frames one JPEG image on a 32-bit big-endian word stream: header words from
// the local RAM, then the entropy words passed through, then one EOI word.
//   clk, resetn        : clock, synchronous active-low reset
//   start_i, abort_i   : begin a frame when idle / kill the current frame
//   hdr_len_i          : header length in words, sampled at start
//   hdr_wr_*_i         : header RAM write port, honoured only while idle
//   in_*_i, in_hold_o  : entropy word input from the byte packer
//   out_*_o, out_hold_i: framed word output to the image buffer writer
//   size_o             : bytes emitted in the current/last frame (saturating)
//   busy_o, done_o     : frame in progress / one-cycle completion pulse
// HDR_DEPTH is expected to be a power of two no larger than 256; header
// addresses wrap by truncation.
module jpeg_stream_sequencer
   import jpeg_pkg::*;
#(
   parameter int unsigned HDR_DEPTH = 256,
   parameter logic [31:0] EOI_WORD  = JPEG_EOI_WORD,
   parameter int unsigned SIZE_W    = JPEG_SIZE_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [7:0]        hdr_len_i,
   input  logic              hdr_wr_en_i,
   input  logic [7:0]        hdr_wr_addr_i,
   input  logic [31:0]       hdr_wr_data_i,
   input  logic [31:0]       in_data_i,
   input  logic              in_tlast_i,
   input  logic              in_valid_i,
   output logic              in_hold_o,
   output logic [31:0]       out_data_o,
   output logic              out_tlast_o,
   output logic              out_valid_o,
   input  logic              out_hold_i,
   output logic [SIZE_W-1:0] size_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned       AddrW   = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
   localparam logic [SIZE_W-1:0] SizeMax = {{(SIZE_W-2){1'b1}}, 2'b00};

   seq_state_t        state_q;
   logic [7:0]        len_q;
   logic [8:0]        hdr_cnt_q, hdr_cnt_d;   // header words loaded into the output register
   logic [31:0]       out_data_q;
   logic              out_valid_q;
   logic              out_tlast_q;
   logic [SIZE_W-1:0] size_q, size_d;
   logic              busy_q;
   logic              done_q;

   logic              xfer;
   logic              start_ok;
   logic              hdr_load;
   logic              in_hold;
   logic              in_acc;
   logic              ram_we;
   logic [31:0]       ram_rdata;

   always_comb begin
      xfer     = out_valid_q & ~out_hold_i;
      start_ok = (state_q == StIdle) & start_i & ~abort_i;
      hdr_load = (state_q == StHdr) & (~out_valid_q | ~out_hold_i) &
                 (hdr_cnt_q != {1'b0, len_q});
      // The RAM is always addressed with the next word to load, so its
      // registered output lines up with the output register one cycle later.
      hdr_cnt_d = start_ok ? 9'd0 : hdr_cnt_q + 9'(hdr_load);
      in_hold   = (state_q != StBody) | (out_valid_q & out_hold_i);
      in_acc    = in_valid_i & ~in_hold;
      ram_we    = hdr_wr_en_i & (state_q == StIdle);
      size_d    = size_q;
      if (xfer) begin
         size_d = (size_q >= SizeMax) ? SizeMax : size_q + SIZE_W'(4);
      end
   end

   hdr_ram #(
      .Depth (HDR_DEPTH),
      .AddrW (AddrW)
   ) u_hdr_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (hdr_wr_addr_i[AddrW-1:0]),
      .wdata_i (hdr_wr_data_i),
      .raddr_i (hdr_cnt_d[AddrW-1:0]),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= StIdle;
         len_q       <= '0;
         hdr_cnt_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_tlast_q <= 1'b0;
         size_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (abort_i && (state_q != StIdle)) begin
         // Drop any word still waiting under hold; size keeps its partial count.
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         out_tlast_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         hdr_cnt_q <= hdr_cnt_d;
         size_q    <= size_d;
         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  len_q   <= hdr_len_i;
                  size_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (hdr_len_i == 8'd0) ? StBody : StHdr;
               end
            end
            StHdr: begin
               if (hdr_load) begin
                  out_data_q  <= ram_rdata;
                  out_valid_q <= 1'b1;
               end else if (xfer) begin
                  out_valid_q <= 1'b0;
                  if (hdr_cnt_q == {1'b0, len_q}) begin
                     state_q <= StBody;
                  end
               end
            end
            StBody: begin
               if (in_acc) begin
                  out_data_q  <= in_data_i;
                  out_valid_q <= 1'b1;
                  if (in_tlast_i) begin
                     state_q <= StEoi;
                  end
               end else if (xfer) begin
                  out_valid_q <= 1'b0;
               end
            end
            StEoi: begin
               // out_tlast_q marks that the EOI word already sits in the register.
               if (out_valid_q && out_tlast_q) begin
                  if (!out_hold_i) begin
                     out_valid_q <= 1'b0;
                     out_tlast_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= StDone;
                  end
               end else if (!out_valid_q || !out_hold_i) begin
                  out_data_q  <= EOI_WORD;
                  out_tlast_q <= 1'b1;
                  out_valid_q <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_hold_o   = in_hold;
   assign out_data_o  = out_data_q;
   assign out_tlast_o = out_tlast_q;
   assign out_valid_o = out_valid_q;
   assign size_o      = size_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Self-checking bench for jpeg_stream_sequencer. A second instance built with
// an 8-bit byte counter shares every input, so its size output exercises
// saturation alongside the full-width instance.
module tb_jpeg_stream_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  hdr_len = '0;
   logic        hdr_wr_en = 1'b0;
   logic [7:0]  hdr_wr_addr = '0;
   logic [31:0] hdr_wr_data = '0;
   logic [31:0] in_data = '0;
   logic        in_tlast = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_hold = 1'b0;

   logic        in_hold, out_tlast, out_valid, busy, done;
   logic [31:0] out_data;
   logic [19:0] size;
   logic        in_hold8, out_tlast8, out_valid8, busy8, done8;
   logic [31:0] out_data8;
   logic [7:0]  size8;

   always #5 clk = ~clk;

   jpeg_stream_sequencer dut (
      .clk (clk), .resetn (resetn), .start_i (start), .abort_i (abort),
      .hdr_len_i (hdr_len), .hdr_wr_en_i (hdr_wr_en), .hdr_wr_addr_i (hdr_wr_addr),
      .hdr_wr_data_i (hdr_wr_data), .in_data_i (in_data), .in_tlast_i (in_tlast),
      .in_valid_i (in_valid), .in_hold_o (in_hold), .out_data_o (out_data),
      .out_tlast_o (out_tlast), .out_valid_o (out_valid), .out_hold_i (out_hold),
      .size_o (size), .busy_o (busy), .done_o (done)
   );

   jpeg_stream_sequencer #(.SIZE_W (8)) dut8 (
      .clk (clk), .resetn (resetn), .start_i (start), .abort_i (abort),
      .hdr_len_i (hdr_len), .hdr_wr_en_i (hdr_wr_en), .hdr_wr_addr_i (hdr_wr_addr),
      .hdr_wr_data_i (hdr_wr_data), .in_data_i (in_data), .in_tlast_i (in_tlast),
      .in_valid_i (in_valid), .in_hold_o (in_hold8), .out_data_o (out_data8),
      .out_tlast_o (out_tlast8), .out_valid_o (out_valid8), .out_hold_i (out_hold),
      .size_o (size8), .busy_o (busy8), .done_o (done8)
   );

   int nvec = 0;
   int nerr = 0;

   // Reference model state.
   logic [31:0] hdr_model [256];
   logic [31:0] body_q[$];
   logic [31:0] exp_data[$];
   bit          exp_last[$];

   // Observed stream and events, recorded on the falling edge.
   logic [31:0] got_data[$];
   bit          got_last[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          hold_viol = 0;
   int          ihold_viol = 0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_data;
   logic        prev_tlast;
   int          first_valid_cyc = -1;
   int          eoi_cyc = -1;
   int          done_cyc = -1;

   // Per-frame results from run_frame.
   int          start_cyc, first_inv_cyc, done0;
   bit          timed_out;
   logic        busy_inj;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data || out_tlast !== prev_tlast))
         hold_viol++;
      if (out_valid && out_hold && !in_hold) ihold_viol++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && !out_hold) begin
         got_data.push_back(out_data);
         got_last.push_back(out_tlast);
         if (out_tlast) eoi_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      prev_hold  = out_valid && out_hold;
      prev_data  = out_data;
      prev_tlast = out_tlast;
   end

   task automatic load_hdr(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      hdr_wr_en = 1'b1; hdr_wr_addr = a; hdr_wr_data = d;
      hdr_model[a] = d;
      @(posedge clk); #1;
      hdr_wr_en = 1'b0;
   endtask

   // Builds the expected stream (header, body_q, EOI) and drives one frame.
   task automatic run_frame(input int len, input int hold_pct, input int valid_pct,
                            input int inject);
      int bi = 0;
      int guard = 0;
      int nbody = body_q.size();
      exp_data.delete(); exp_last.delete(); got_data.delete(); got_last.delete();
      for (int i = 0; i < len; i++) begin
         exp_data.push_back(hdr_model[i]); exp_last.push_back(1'b0);
      end
      for (int i = 0; i < nbody; i++) begin
         exp_data.push_back(body_q[i]); exp_last.push_back(1'b0);
      end
      exp_data.push_back(32'hFFFF_FFD9); exp_last.push_back(1'b1);
      hold_viol = 0; ihold_viol = 0; timed_out = 1'b0; busy_inj = 1'bx;
      done0 = done_cnt; first_inv_cyc = -1;
      @(posedge clk); #1;
      hdr_len = 8'(len); start = 1'b1; start_cyc = cyc;
      first_valid_cyc = -1; eoi_cyc = -1; done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b0;
      while (done_cnt == done0) begin
         if (guard > 2000) begin
            timed_out = 1'b1;
            break;
         end
         guard++;
         out_hold = ($urandom_range(99) < hold_pct);
         if (bi < nbody && $urandom_range(99) < valid_pct) begin
            in_valid = 1'b1; in_data = body_q[bi]; in_tlast = (bi == nbody - 1);
            if (first_inv_cyc < 0) first_inv_cyc = cyc;
         end else begin
            in_valid = 1'b0; in_tlast = 1'b0;
         end
         if (guard == inject) begin
            start = 1'b1; hdr_wr_en = 1'b1; hdr_wr_addr = 8'd0; hdr_wr_data = 32'hDEAD_BEEF;
            busy_inj = busy;
         end else begin
            start = 1'b0; hdr_wr_en = 1'b0;
         end
         @(negedge clk);
         if (in_valid && !in_hold) bi++;
         @(posedge clk); #1;
      end
      out_hold = 1'b0; in_valid = 1'b0; in_tlast = 1'b0; start = 1'b0; hdr_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nvec++;
      if ({out_valid, out_tlast, out_data, in_hold, busy, done, size, size8} !==
          {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 20'h0, 8'h0}) begin
         nerr++;
         $display("FAIL reset: valid=%b tlast=%b data=%h in_hold=%b busy=%b done=%b size=%0d/%0d, want 0 0 0 1 0 0 0/0",
                  out_valid, out_tlast, out_data, in_hold, busy, done, size, size8);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   task automatic test_header_body();
      load_hdr(8'd0, 32'hFFD8_FFE0);
      load_hdr(8'd1, 32'h0010_4A46);
      load_hdr(8'd2, 32'h4946_0001);
      load_hdr(8'd3, 32'hFFDA_000C);
      body_q = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4};
      run_frame(4, 0, 100, 0);
      nvec++;
      if (timed_out || got_data.size() != exp_data.size()) begin
         nerr++;
         $display("FAIL hb_count: got %0d words (timeout=%0b), want %0d", got_data.size(), timed_out,
                  exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         nvec++;
         if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
            nerr++;
            $display("FAIL hb_word%0d: got %b/%h want %b/%h", i, got_last[i], got_data[i],
                     exp_last[i], exp_data[i]);
         end
      end
      nvec++;
      if (first_valid_cyc - start_cyc != 2) begin
         nerr++;
         $display("FAIL hb_first_latency: got %0d want 2", first_valid_cyc - start_cyc);
      end
      nvec++;
      if (done_cyc - eoi_cyc != 1) begin
         nerr++;
         $display("FAIL hb_done_timing: got %0d cycles after EOI want 1", done_cyc - eoi_cyc);
      end
      nvec++;
      if (size !== 20'd32 || size8 !== 8'd32) begin
         nerr++;
         $display("FAIL hb_size: got %0d/%0d want 32/32", size, size8);
      end
      nvec++;
      if (busy !== 1'b0 || done_cnt - done0 != 1) begin
         nerr++;
         $display("FAIL hb_busy_done: busy=%b pulses=%0d want busy=0 pulses=1", busy,
                  done_cnt - done0);
      end
   endtask

   task automatic test_zero_hdr();
      body_q = '{$urandom};
      run_frame(0, 0, 100, 0);
      nvec++;
      if (timed_out || got_data.size() != 2) begin
         nerr++;
         $display("FAIL zh_count: got %0d words want 2", got_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         nvec++;
         if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
            nerr++;
            $display("FAIL zh_word%0d: got %b/%h want %b/%h", i, got_last[i], got_data[i],
                     exp_last[i], exp_data[i]);
         end
      end
      nvec++;
      if (first_valid_cyc - first_inv_cyc < 1 || first_valid_cyc - first_inv_cyc > 2) begin
         nerr++;
         $display("FAIL zh_latency: got %0d cycles want 1..2", first_valid_cyc - first_inv_cyc);
      end
      nvec++;
      if (size !== 20'd8 || size8 !== 8'd8) begin
         nerr++;
         $display("FAIL zh_size: got %0d/%0d want 8/8", size, size8);
      end
   endtask

   task automatic test_backpressure();
      for (int it = 0; it < 3; it++) begin
         int len = $urandom_range(6, 1);
         for (int a = 0; a < len; a++) load_hdr(8'(a), $urandom);
         body_q.delete();
         for (int b = 0; b < int'($urandom_range(20, 5)); b++) body_q.push_back($urandom);
         run_frame(len, 50, 70, 0);
         nvec++;
         if (timed_out || got_data.size() != exp_data.size()) begin
            nerr++;
            $display("FAIL bp%0d_count: got %0d words want %0d", it, got_data.size(),
                     exp_data.size());
         end
         for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            nvec++;
            if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
               nerr++;
               $display("FAIL bp%0d_word%0d: got %b/%h want %b/%h", it, i, got_last[i],
                        got_data[i], exp_last[i], exp_data[i]);
            end
         end
         nvec++;
         if (hold_viol != 0 || ihold_viol != 0) begin
            nerr++;
            $display("FAIL bp%0d_hold: unstable=%0d in_hold_low=%0d want 0/0", it, hold_viol,
                     ihold_viol);
         end
         nvec++;
         if (size !== 20'(4 * got_data.size()) || size !== 20'(4 * exp_data.size())) begin
            nerr++;
            $display("FAIL bp%0d_size: got %0d want %0d", it, size, 4 * exp_data.size());
         end
      end
   endtask

   task automatic test_abort();
      int bi = 0;
      int guard = 0;
      done0 = done_cnt;
      @(posedge clk); #1;
      hdr_len = 8'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (bi < 2 && guard < 200) begin
         in_valid = 1'b1; in_data = $urandom; in_tlast = 1'b0;
         @(negedge clk);
         if (in_valid && !in_hold) bi++;
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nvec++;
      if (busy !== 1'b1 || in_hold !== 1'b0) begin
         nerr++;
         $display("FAIL ab_pre: busy=%b in_hold=%b want 1/0", busy, in_hold);
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      nvec++;
      if ({out_valid, busy, in_hold} !== 3'b001) begin
         nerr++;
         $display("FAIL ab_post: valid=%b busy=%b in_hold=%b want 0 0 1", out_valid, busy, in_hold);
      end
      repeat (5) @(posedge clk);
      #1;
      nvec++;
      if (done_cnt != done0 || size !== 20'd16) begin
         nerr++;
         $display("FAIL ab_size_done: size=%0d pulses=%0d want 16/0", size, done_cnt - done0);
      end
      body_q = '{$urandom, $urandom, $urandom};
      run_frame(4, 0, 100, 0);
      nvec++;
      if (timed_out || got_data.size() != 8 || size !== 20'd32) begin
         nerr++;
         $display("FAIL ab_restart: words=%0d size=%0d want 8/32", got_data.size(), size);
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         nvec++;
         if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
            nerr++;
            $display("FAIL ab_word%0d: got %b/%h want %b/%h", i, got_last[i], got_data[i],
                     exp_last[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_busy_illegal();
      load_hdr(8'd0, 32'hFFD8_FFE0);
      load_hdr(8'd1, 32'h0010_4A46);
      load_hdr(8'd2, 32'h4946_0001);
      load_hdr(8'd3, 32'hFFDA_000C);
      body_q = '{$urandom, $urandom, $urandom};
      run_frame(4, 0, 100, 3);
      nvec++;
      if (busy_inj !== 1'b1 || timed_out || got_data.size() != exp_data.size()) begin
         nerr++;
         $display("FAIL il_frame: busy_at_inject=%b words=%0d want 1/%0d", busy_inj,
                  got_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         nvec++;
         if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
            nerr++;
            $display("FAIL il_word%0d: got %b/%h want %b/%h", i, got_last[i], got_data[i],
                     exp_last[i], exp_data[i]);
         end
      end
      repeat (4) @(posedge clk);
      #1;
      nvec++;
      if (busy !== 1'b0 || done_cnt - done0 != 1) begin
         nerr++;
         $display("FAIL il_restart: busy=%b pulses=%0d want 0/1", busy, done_cnt - done0);
      end
      body_q = '{$urandom};
      run_frame(4, 0, 100, 0);
      nvec++;
      if (got_data.size() == 0 || got_data[0] !== 32'hFFD8_FFE0) begin
         nerr++;
         $display("FAIL il_word0: got %h want ffd8ffe0",
                  (got_data.size() > 0) ? got_data[0] : 32'h0);
      end
   endtask

   task automatic test_saturation();
      body_q.delete();
      for (int b = 0; b < 70; b++) body_q.push_back($urandom);
      run_frame(0, 30, 100, 0);
      nvec++;
      if (timed_out || got_data.size() != 71) begin
         nerr++;
         $display("FAIL sat_count: got %0d words want 71", got_data.size());
      end
      nvec++;
      if (size8 !== 8'd252) begin
         nerr++;
         $display("FAIL sat_size8: got %0d want 252", size8);
      end
      nvec++;
      if (size !== 20'd284) begin
         nerr++;
         $display("FAIL sat_size20: got %0d want 284", size);
      end
   endtask

   initial begin
      test_reset();
      test_header_body();
      test_zero_hdr();
      test_backpressure();
      test_abort();
      test_busy_illegal();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
